// File: rtl/alu_bcd_conv.sv
// ALU result to packed BCD converter: iterative shift-add-3 with sign, overflow
// and leading-zero blanking for the display driver. Divide mode converts quotient/remainder separately.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one add-3/shift step per clock, N steps total
// DONE  | one-cycle done pulse, then back to IDLE
module alu_bcd_conv #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2*WIDTH-1:0]    value_i,
  input  logic [1:0]            func_i,
  input  logic                  ovf_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic                  neg_o,
  output logic                  err_o
);

  localparam int CW = $clog2(2*WIDTH+1);
  localparam int BW = 4*DIGITS;
  localparam int HW = 2*DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]      scr_q, scr_d, scr_adj;
  logic               div_q, neg_cap_q, ovf_cap_q;
  logic               done_q, neg_q, err_q;
  logic [BW-1:0]      bcd_q;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic [WIDTH-1:0]   mag;

  assign mag = ~value_i[WIDTH-1:0] + 1'b1;

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    if (div_q) begin
      // Quotient feeds the upper field, remainder the lower; no carry between them.
      scr_d = {scr_adj[BW-2:HW], bin_q[2*WIDTH-1], scr_adj[HW-2:0], bin_q[WIDTH-1]};
      bin_d = {bin_q[2*WIDTH-2:WIDTH], 1'b0, bin_q[WIDTH-2:0], 1'b0};
    end else begin
      scr_d = {scr_adj[BW-2:0], bin_q[2*WIDTH-1]};
      bin_d = {bin_q[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    logic seen;
    blank_d = '0;
    seen    = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      if (div_q && i == DIGITS/2-1) seen = 1'b0;
      seen = seen | (scr_d[4*i +: 4] != 4'd0);
      blank_d[i] = !seen && (i != 0) && !(div_q && i == DIGITS/2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      scr_q     <= '0;
      div_q     <= 1'b0;
      neg_cap_q <= 1'b0;
      ovf_cap_q <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q   <= SHIFT;
          scr_q     <= '0;
          ovf_cap_q <= ovf_i;
          div_q     <= (func_i == 2'b11);
          cnt_q     <= (func_i == 2'b11) ? CW'(WIDTH) : CW'(2*WIDTH);
          neg_cap_q <= 1'b0;
          bin_q     <= value_i;
          if (!func_i[1]) begin
            if (value_i[WIDTH-1]) begin
              bin_q     <= {{WIDTH{1'b0}}, mag};
              neg_cap_q <= 1'b1;
            end else begin
              bin_q     <= {{WIDTH{1'b0}}, value_i[WIDTH-1:0]};
            end
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            bcd_q   <= scr_d;
            blank_q <= blank_d;
            neg_q   <= neg_cap_q;
            err_q   <= ovf_cap_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == SHIFT);
  assign done_o  = done_q;
  assign bcd_o   = bcd_q;
  assign blank_o = blank_q;
  assign neg_o   = neg_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_alu_bcd_conv.sv
// Directed vector bench for alu_bcd_conv: table of conversions plus
// hand-written sequences for ignored restart and mid-conversion reset.
module tb_alu_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] value = '0;
  logic [1:0]  func = '0;
  logic        ovf = 1'b0;
  logic        busy, done, neg, err;
  logic [15:0] bcd;
  logic [3:0]  blank;

  int checks = 0;
  int errors = 0;

  alu_bcd_conv #(.WIDTH(6), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .value_i(value), .func_i(func),
    .ovf_i(ovf), .busy_o(busy), .done_o(done), .bcd_o(bcd), .blank_o(blank),
    .neg_o(neg), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  func;
    logic [11:0] value;
    logic        ovf;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        neg;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int cyc = 0;
    int busy_cnt = 0;
    @(negedge clk);
    func = v.func; value = v.value; ovf = v.ovf; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    value = ~v.value;
    func = ~v.func;
    ovf = ~v.ovf;
    forever begin
      @(negedge clk);
      cyc++;
      if (done || cyc > 40) break;
      if (busy) busy_cnt++;
    end
    chk("latency", cyc - 1, v.lat);
    chk("busy_cycles", busy_cnt, v.lat);
    chk("bcd", bcd, v.bcd);
    chk("blank", blank, v.blank);
    chk("neg", neg, v.neg);
    chk("err", err, v.err);
    @(negedge clk);
    chk("done_width", done, 1'b0);
    chk("hold_bcd", bcd, v.bcd);
  endtask

  initial begin
    int dcnt;
    vec_t v;
    vecs[0] = '{2'b10, 12'd4095, 1'b0, 16'h4095, 4'b0000, 1'b0, 1'b0, 12};
    vecs[1] = '{2'b11, {6'd7, 6'd5}, 1'b0, 16'h0705, 4'b1010, 1'b0, 1'b0, 6};
    vecs[2] = '{2'b01, 12'h03B, 1'b0, 16'h0005, 4'b1110, 1'b1, 1'b0, 12};
    vecs[3] = '{2'b00, 12'h020, 1'b1, 16'h0032, 4'b1100, 1'b1, 1'b1, 12};
    vecs[4] = '{2'b10, 12'd0, 1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0, 12};
    vecs[5] = '{2'b01, 12'hF1F, 1'b0, 16'h0031, 4'b1100, 1'b0, 1'b0, 12};
    vecs[6] = '{2'b11, {6'd63, 6'd63}, 1'b0, 16'h6363, 4'b0000, 1'b0, 1'b0, 6};
    vecs[7] = '{2'b11, 12'd0, 1'b1, 16'h0000, 4'b1010, 1'b0, 1'b1, 6};
    vecs[8] = '{2'b10, 12'd2748, 1'b1, 16'h2748, 4'b0000, 1'b0, 1'b1, 12};
    vecs[9] = '{2'b10, 12'd1000, 1'b0, 16'h1000, 4'b0000, 1'b0, 1'b0, 12};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", {bcd, blank, neg, err}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run(vecs[i]);

    // Restart while busy must be ignored; input change after capture has no effect.
    @(negedge clk);
    func = 2'b10; value = 12'd0; ovf = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    value = 12'd100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("restart_done_count", dcnt, 1);
    chk("restart_bcd", bcd, 16'h0000);
    chk("restart_blank", blank, 4'b1110);

    run(vecs[3]);

    // Reset during SHIFT abandons the conversion.
    @(negedge clk);
    func = 2'b10; value = 12'd999; ovf = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out", {bcd, blank, neg, err, done}, '0);
    dcnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);
    v = '{2'b10, 12'd999, 1'b0, 16'h0999, 4'b1000, 1'b0, 1'b0, 12};
    run(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_bcd_conv.md
Name: alu_bcd_conv

Overview:
Downstream stage of the ALU. It captures one ALU result (`out`, `ovf`, `func`) on a start pulse and converts it to packed BCD with an iterative shift-add-3 (double-dabble) state machine. It also produces sign, overflow and leading-zero blanking information for the seven-segment display driver. In divide mode the quotient and remainder are converted as two independent BCD fields.

Parameters:
- WIDTH, 6, ALU operand width; the result bus is 2*WIDTH bits.
- DIGITS, 4, BCD digits produced. Must satisfy 10^DIGITS > 2^(2*WIDTH)-1 and 10^(DIGITS/2) > 2^WIDTH-1. DIGITS is even.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request conversion; sampled only in IDLE.
- value, in, 2*WIDTH, ALU result (`out`).
- func, in, 2, ALU function code that produced value.
- ovf, in, 1, ALU overflow flag.
- busy, out, 1, conversion in progress (SHIFT state).
- done, out, 1, one-cycle pulse; result outputs valid and updated.
- bcd, out, 4*DIGITS, packed BCD; digit i is bcd[4i+3:4i].
- blank, out, DIGITS, bit i=1 means digit i is a leading zero to suppress.
- neg, out, 1, result is negative (add/sub modes only).
- err, out, 1, captured ovf.

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset (asserted at any time, including mid-SHIFT):
  - state goes to IDLE and the shift counter clears.
  - busy=0, done=0, bcd=0, blank=0, neg=0, err=0.
  - A conversion in progress is abandoned and produces no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE with start=1 at edge E0:
  - Capture func, ovf and the operand into internal registers; clear the BCD scratch; go to SHIFT. busy=1 from E0.
  - Shift count N = 2*WIDTH for func 00/01/10, N = WIDTH for func 11.
- Operand formation at capture:
  - func 00/01: take value[WIDTH-1:0] as two's complement. If value[WIDTH-1]=1, magnitude = -value[WIDTH-1:0] as a WIDTH-bit unsigned number (e.g. -32 gives 32) and neg=1; otherwise neg=0. value[2*WIDTH-1:WIDTH] is ignored.
  - func 10: unsigned, all 2*WIDTH bits, neg=0.
  - func 11: upper WIDTH bits are the quotient and lower WIDTH bits the remainder, both unsigned, neg=0.
- SHIFT, one step per edge E1..EN:
  - First, every BCD nibble >= 5 gets +3.
  - Then the BCD scratch and binary operand shift left 1 as a single chain.
  - In func 11 mode the chain is split: the upper DIGITS/2 nibbles take the quotient MSB, and the lower DIGITS/2 nibbles take the remainder MSB. No carry passes between the fields.
- At edge EN:
  - Go to DONE and register bcd, blank, neg and err.
  - busy falls at EN; done=1 for exactly the cycle following EN.
- DONE to IDLE at the next edge; done returns to 0.
- start is ignored in SHIFT and DONE and is not queued. Minimum start-to-start spacing is N+2 cycles.
- Outputs hold their last result until the next done or reset.
- Blanking:
  - Non-div modes: blank bit i=1 if digit i and all higher digits are 0. Digit 0 is never blanked.
  - func 11: blanking is applied per field. Digits 0 and DIGITS/2 are never blanked.
- err is the captured ovf only. bcd is still converted from value when err=1.
- Value and func changes after capture do not affect the conversion in flight.

Test Plan:
1. func=10, value=12'd4095, start pulse -> done 12 edges after the start edge; bcd=16'h4095, blank=4'b0000, neg=0, err=0; busy high for exactly 12 cycles.
2. func=11, value={6'd7,6'd5} -> done 6 edges after start; bcd=16'h0705, blank=4'b1010, neg=0.
3. func=01, value=12'h03B (low 6 bits = -5), ovf=0 -> neg=1, bcd=16'h0005, blank=4'b1110, err=0.
4. func=00, value low bits=6'b100000 (-32), ovf=1 -> neg=1, bcd=16'h0032, blank=4'b1100, err=1.
5. func=10, value=0 -> bcd=16'h0000, blank=4'b1110. Then func=10, value=12'd100 with start re-pulsed 3 cycles later while busy -> the second start is ignored, exactly one done occurs, bcd=16'h0000.
6. Start func=10, value=12'd999; drop rst_n at the 5th shift cycle -> all outputs 0 immediately, no done. After release, start with value=12'd999 -> bcd=16'h0999, blank=4'b1000.
